// File: rtl/double_trouble_pkg.sv
// Shared types and helpers for the double_trouble_tally window counter:
// FSM state encoding, default window length and the strict-majority compare.
package double_trouble_pkg;

    localparam int DEFAULT_WINDOW = 16;

    // Wide enough for any legal window (<= 1023) and its count.
    localparam int MAJ_W = 11;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // Strict majority: 2*count > window. The doubled value carries one extra
    // bit so it can never wrap; a tie therefore reports 0.
    function automatic logic majority_of(input logic [MAJ_W-1:0] count,
                                         input logic [MAJ_W-1:0] window);
        logic [MAJ_W:0] doubled;
        doubled = {count, 1'b0};
        return (doubled > {1'b0, window});
    endfunction

endpackage

// File: rtl/double_trouble_tally.sv
// Windowed tally of detector hits with a strict-majority verdict on a
// valid/ready result port. DOUBLE_TROUBLE_TALLY_RUN_EN adds longest-run tracking.
module double_trouble_tally
    import double_trouble_pkg::*;
#(
    parameter  int WINDOW = DEFAULT_WINDOW,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_majority
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
    ,
    output logic [CNT_W-1:0] out_max_run
`endif
);

    state_t           state_r;
    logic [CNT_W-1:0] sample_cnt_r;
    logic [CNT_W-1:0] hit_cnt_r;

    logic             accept_s;
    logic             close_s;
    logic             handshake_s;
    logic [CNT_W-1:0] hit_next_s;

    // Handshake strobes are decoded from the registered state only.
    assign in_ready  = (state_r == COLLECT);
    assign out_valid = (state_r == EMIT);

    // Accept / window-close / result-taken strobes and the next hit count.
    always_comb begin
        accept_s    = in_valid && in_ready;
        close_s     = accept_s && (sample_cnt_r == CNT_W'(WINDOW - 1));
        handshake_s = out_valid && out_ready;
        if (in_flag) begin
            hit_next_s = hit_cnt_r + CNT_W'(1);
        end else begin
            hit_next_s = hit_cnt_r;
        end
    end

    // Collect/emit state machine with the registered count and verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= COLLECT;
            sample_cnt_r <= {CNT_W{1'b0}};
            hit_cnt_r    <= {CNT_W{1'b0}};
            out_count    <= {CNT_W{1'b0}};
            out_majority <= 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        sample_cnt_r <= sample_cnt_r + CNT_W'(1);
                        hit_cnt_r    <= hit_next_s;
                        if (close_s) begin
                            out_count    <= hit_next_s;
                            out_majority <= majority_of(MAJ_W'(hit_next_s), MAJ_W'(WINDOW));
                            state_r      <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    // Results hold until taken; samples are stalled meanwhile.
                    if (handshake_s) begin
                        sample_cnt_r <= {CNT_W{1'b0}};
                        hit_cnt_r    <= {CNT_W{1'b0}};
                        state_r      <= COLLECT;
                    end
                end
                default: begin
                    state_r      <= COLLECT;
                    sample_cnt_r <= {CNT_W{1'b0}};
                    hit_cnt_r    <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
    logic [CNT_W-1:0] cur_run_r;
    logic [CNT_W-1:0] max_run_r;
    logic [CNT_W-1:0] cur_run_next_s;
    logic [CNT_W-1:0] max_run_next_s;

    // Run length including the offered sample, and the best run so far.
    always_comb begin
        if (in_flag) begin
            cur_run_next_s = cur_run_r + CNT_W'(1);
        end else begin
            cur_run_next_s = {CNT_W{1'b0}};
        end
        if (cur_run_next_s > max_run_r) begin
            max_run_next_s = cur_run_next_s;
        end else begin
            max_run_next_s = max_run_r;
        end
    end

    // Run tracker registers, advanced only on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_run_r   <= {CNT_W{1'b0}};
            max_run_r   <= {CNT_W{1'b0}};
            out_max_run <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cur_run_r <= cur_run_next_s;
            max_run_r <= max_run_next_s;
            if (close_s) begin
                out_max_run <= max_run_next_s;
            end else begin
                out_max_run <= out_max_run;
            end
        end else if (handshake_s) begin
            cur_run_r <= {CNT_W{1'b0}};
            max_run_r <= {CNT_W{1'b0}};
        end else begin
            cur_run_r <= cur_run_r;
            max_run_r <= max_run_r;
        end
    end
`endif

endmodule

// File: tb/tb_double_trouble_tally.sv
// Randomized and directed bench for double_trouble_tally against a
// queue-based window model. Honours DOUBLE_TROUBLE_TALLY_RUN_EN.
module tb_double_trouble_tally;

    localparam int WINDOW = 16;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_flag;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_majority;
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
    logic [CNT_W-1:0] out_max_run;
`endif

    double_trouble_tally #(.WINDOW(WINDOW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flag      (in_flag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_majority (out_majority)
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
        ,
        .out_max_run  (out_max_run)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the flags accepted so far in this window, plus
    // whether a finished window is waiting to be taken.
    bit m_emit = 1'b0;
    bit q[$];
    int e_count = 0;
    int e_maj   = 0;
    int e_run   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_emit = 1'b0;
        q.delete();
    endtask

    task automatic close_window();
        int run;
        e_count = 0;
        e_run   = 0;
        run     = 0;
        foreach (q[i]) begin
            if (q[i]) begin
                e_count++;
                run++;
            end else begin
                run = 0;
            end
            if (run > e_run) e_run = run;
        end
        e_maj  = (2 * e_count > WINDOW) ? 1 : 0;
        m_emit = 1'b1;
    endtask

    // Compare the outputs against the model, then drive the next cycle's
    // inputs and advance the model by what the coming edge will do.
    task automatic step(input bit iv, input bit fl, input bit ordy);
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(!m_emit));
        check("out_valid", 32'(out_valid), 32'(m_emit));
        if (m_emit) begin
            check("out_count", 32'(out_count), 32'(e_count));
            check("out_majority", 32'(out_majority), 32'(e_maj));
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
            check("out_max_run", 32'(out_max_run), 32'(e_run));
`endif
        end
        in_valid  = iv;
        in_flag   = fl;
        out_ready = ordy;
        if (!m_emit) begin
            if (iv) begin
                q.push_back(fl);
                if (q.size() == WINDOW) close_window();
            end
        end else if (ordy) begin
            model_reset();
        end
    endtask

    // Asynchronous reset pulse placed away from any clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_out_majority", 32'(out_majority), 32'd0);
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
        check("rst_out_max_run", 32'(out_max_run), 32'd0);
`endif
        #2 rst = 1'b0;
    endtask

    bit flags[WINDOW];
    int gap_at[3];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_flag   = 1'b0;
        out_ready = 1'b0;
        #12;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_out_count", 32'(out_count), 32'd0);
        check("init_out_majority", 32'(out_majority), 32'd0);
        rst = 1'b0;

        // All ones on consecutive cycles.
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("ones_valid", 32'(out_valid), 32'd1);
        check("ones_count", 32'(out_count), 32'(WINDOW));
        check("ones_majority", 32'(out_majority), 32'd1);
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
        check("ones_run", 32'(out_max_run), 32'(WINDOW));
`endif

        // Alternating 1,0,... gives a tie for an even window.
        for (int i = 0; i < WINDOW; i++) step(1'b1, ((i % 2) == 0), 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("alt_count", 32'(out_count), 32'(WINDOW / 2));
        check("alt_majority", 32'(out_majority), 32'((2 * (WINDOW / 2)) > WINDOW));
`ifdef DOUBLE_TROUBLE_TALLY_RUN_EN
        check("alt_run", 32'(out_max_run), 32'd1);
`endif

        // WINDOW/2+1 ones shuffled, with three idle gaps carrying junk flags.
        for (int i = 0; i < WINDOW; i++) flags[i] = (i < WINDOW / 2 + 1);
        for (int i = WINDOW - 1; i > 0; i--) begin
            int j;
            bit t;
            j = int'($urandom_range(0, i));
            t = flags[i];
            flags[i] = flags[j];
            flags[j] = t;
        end
        for (int g = 0; g < 3; g++) gap_at[g] = int'($urandom_range(1, WINDOW - 1));
        for (int i = 0; i < WINDOW; i++) begin
            for (int g = 0; g < 3; g++) begin
                if (gap_at[g] == i) step(1'b0, 1'($urandom), 1'b1);
            end
            step(1'b1, flags[i], 1'b0);
        end
        // Stall in EMIT while samples keep being offered.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, k[0], 1'b0);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_count", 32'(out_count), 32'(WINDOW / 2 + 1));
            check("hold_majority", 32'(out_majority), 32'd1);
        end
        step(1'b1, 1'b1, 1'b1);
        // Next window starts from zero.
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("after_hold_count", 32'(out_count), 32'd0);

        // Reset after seven accepts, then an all-zero window.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1);
        pulse_reset();
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("post_rst_count", 32'(out_count), 32'd0);
        check("post_rst_majority", 32'(out_majority), 32'd0);

        // Randomized traffic, with biased flags to hit both verdicts.
        for (int i = 0; i < 3000; i++) begin
            bit iv;
            bit fl;
            bit ordy;
            iv   = ($urandom_range(0, 9) < 7);
            fl   = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            step(iv, fl, ordy);
            if (i == 1500) pulse_reset();
        end
        step(1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
